inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
Instruction-fetch front end; the producer side of the decode stage's instruction interface. It generates the sequential PC, issues single-outstanding read requests to instruction memory over a req/ack handshake, and buffers returned words in a small prefetch FIFO. It presents {pc, inst, valid} to the IF/ID pipeline register, honours a downstream stall, and accepts a PC redirect that flushes all fetched-but-unconsumed instructions.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits[1:0] must be 0
FIFO_DEPTH, 2, prefetch buffer entries; legal values 2..8
CNT_W, 4, width of the occupancy/credit counters; must hold FIFO_DEPTH

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
imem_req_o  out  1  read request to instruction memory
imem_addr_o  out  32  word-aligned fetch address; stable while imem_req_o=1
imem_ack_i  in  1  memory accepted and returned data this cycle
imem_rdata_i  in  32  instruction word; valid only when imem_ack_i=1
stall_i  in  1  downstream not ready; head entry must not be popped
redirect_i  in  1  one-cycle pulse: flush and restart fetch
redirect_pc_i  in  32  new fetch address; bits[1:0] ignored (forced 0)
inst_valid_o  out  1  head entry valid
pc_o  out  32  PC of head instruction
inst_o  out  32  head instruction word

Behaviour:
- Reset (rst=1 at an edge): imem_req_o=0, imem_addr_o=RESET_PC, FIFO empty, inst_valid_o=0, pc_o=0, inst_o=0, fetch_pc=RESET_PC, discard flag=0.
- Outputs when FIFO empty: inst_valid_o=0, pc_o=0, inst_o=0 (decodes as NOP). When non-empty: head entry, driven combinationally from FIFO storage.
- Handshake: one outstanding request. imem_req_o is registered. Once asserted, req and addr stay stable until the edge at which imem_ack_i=1. Any number of wait cycles is legal. imem_ack_i while req=0 is a protocol violation and is ignored.
- Credit rule: at each edge, req_next = (count_next + inflight_next) < FIFO_DEPTH, evaluated after this cycle's push/pop. With zero-wait memory and no stall, this gives one word per cycle back-to-back.
- On ack edge: if discard=0, push {imem_addr_o, imem_rdata_i} and set fetch_pc = addr+4. The +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). If discard=1, drop the data, clear discard, and do not push.
- Pop: at an edge with inst_valid_o=1 and stall_i=0. Push and pop in the same cycle leave the count unchanged. Overflow is impossible by the credit rule; a push into a full FIFO is an assertion failure.
- Redirect (redirect_i=1 at an edge):
  - The FIFO is emptied; inst_valid_o=0 the next cycle, regardless of stall_i.
  - fetch_pc = {redirect_pc_i[31:2],2'b00}.
  - No request in flight: the next request uses the new PC immediately (req=1, addr=new PC next cycle).
  - Request in flight with no ack this edge: req stays high on the old address until ack; discard is set, so that data is dropped. The new-PC request follows at the next edge.
  - Ack on the same edge as redirect: the returned data is dropped; discard is not set.
  - Redirect takes priority over push and pop.
- Latency: the first req rises at the first edge with rst=0. The instruction is visible (inst_valid_o=1) in the cycle after its ack. From redirect to first valid instruction is 2 cycles minimum.
- Reset mid-operation: the in-flight request is abandoned and the memory side must tolerate it. All state returns to reset values at that edge.

Decomposition:
- defs.v gains `ResetPC, `FetchDepth, and reuses `InstAddrBus, `InstBus, `ZeroWord, `RstEnable.
- Sub-module fetch_fifo: parameterised circular buffer of {pc,inst} with push/pop/flush, count output and head read port.
- inst_fetch_unit holds the request FSM (IDLE, REQ, REQ_DISCARD), fetch_pc and credit logic.

Test Plan:
- Zero-wait memory (ack=req), stall_i=0 from reset: consecutive cycles show pc_o 0x0,0x4,0x8,0xC with matching inst_o; imem_req_o continuously 1.
- Memory with 3 wait cycles: imem_addr_o held at 0x4 for 4 cycles; inst_valid_o pulses once per 4 cycles; no duplicates or skips.
- stall_i=1 held, DEPTH=2: after 2 acks, imem_req_o=0 and head stays pc_o=0x0. Release stall: pops 0x0,0x4, then req resumes at 0x8.
- Redirect to 0x0000_0102 while a request to 0x10 is in flight with 2 wait cycles: the 0x10 data is dropped and the FIFO is flushed. Next address is 0x100; first valid pc_o=0x100.
- RESET_PC=32'hFFFF_FFF8, zero-wait: pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst pulsed mid-stream with a full FIFO: the next cycle shows inst_valid_o=0, imem_req_o=0; fetching restarts from RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the default parameter values, the fetch request state type,
// the {pc, inst} entry stored in the prefetch buffer and a PC
// alignment helper used wherever an address enters the fetch path.
package inst_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int          DEFAULT_FIFO_DEPTH = 2;
    localparam int          DEFAULT_CNT_W      = 4;
    localparam logic [31:0] ZERO_WORD          = 32'h0000_0000;
    localparam logic [31:0] PC_STEP            = 32'd4;

    // IDLE: no request on the bus. REQ: request outstanding, data kept.
    // REQ_DISCARD: request outstanding but a redirect made its data stale.
    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_REQ_DISCARD
    } fetchState_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetchEntry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] alignPc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Prefetch buffer: circular buffer of {pc, inst} entries.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   i_push       write i_entry at the tail
//   i_pop        retire the head entry
//   i_flush      drop every entry (wins over push and pop)
//   i_entry      entry to write
//   o_head       current head entry (meaningful only when o_count != 0)
//   o_count      number of valid entries
module inst_fetch_unit_fetch_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  fetchEntry_t      i_entry,
    output fetchEntry_t      o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetchEntry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Storage has no reset; stale words are never visible because the
    // count gates every read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_entry;
        end
    end

    // Pointer and occupancy bookkeeping; flush simply rewinds everything.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            assert (!(i_push && !i_pop && (r_count == CNT_W'(DEPTH))));
            assert (!(i_pop && (r_count == '0)));
            if (i_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (i_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID register.
// Generates sequential PCs, keeps at most one read outstanding on the
// instruction memory req/ack handshake, buffers returned words in the
// prefetch FIFO and presents the head as {pc, inst, valid}.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_o, imem_addr_o          registered memory request and address
//   imem_ack_i, imem_rdata_i         memory acknowledge with returned word
//   stall_i                          downstream not ready, hold the head
//   redirect_i, redirect_pc_i        flush and restart fetch at a new PC
//   inst_valid_o, pc_o, inst_o       head entry (zeros when empty)
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int          CNT_W      = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    fetchState_e      r_state;
    logic             r_req;
    logic [31:0]      r_addr;
    logic [31:0]      r_fetchPc;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_countNext;
    fetchEntry_t      w_head;
    fetchEntry_t      w_pushEntry;
    logic             w_ack;
    logic             w_discarding;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_stillPending;
    logic             w_issue;
    logic [31:0]      w_fetchPcNext;

    // Per-edge decisions. An ack with no request is ignored. A redirect
    // drops whatever returns on its edge and empties the buffer. A new
    // request is only issued when the buffer will still have room for
    // its data once this cycle's push and pop have happened.
    always_comb begin
        w_ack          = imem_ack_i && r_req;
        w_discarding   = (r_state == FETCH_REQ_DISCARD);
        w_valid        = (w_count != '0);
        w_push         = w_ack && !w_discarding && !redirect_i;
        w_pop          = w_valid && !stall_i && !redirect_i;
        w_stillPending = r_req && !w_ack;

        if (redirect_i) begin
            w_countNext = '0;
        end else begin
            w_countNext = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end

        w_issue = !w_stillPending && (w_countNext < CNT_W'(FIFO_DEPTH));

        if (redirect_i) begin
            w_fetchPcNext = alignPc(redirect_pc_i);
        end else if (w_push) begin
            w_fetchPcNext = r_addr + PC_STEP;
        end else begin
            w_fetchPcNext = r_fetchPc;
        end
    end

    // Request FSM. While a request is outstanding req and addr are frozen;
    // a redirect during that time only marks the data for discard, and the
    // request to the new PC goes out after the stale ack arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH_IDLE;
            r_req     <= 1'b0;
            r_addr    <= RESET_PC;
            r_fetchPc <= RESET_PC;
        end else begin
            r_fetchPc <= w_fetchPcNext;
            if (w_stillPending) begin
                r_state <= (redirect_i || w_discarding) ? FETCH_REQ_DISCARD : FETCH_REQ;
            end else if (w_issue) begin
                r_state <= FETCH_REQ;
                r_req   <= 1'b1;
                r_addr  <= w_fetchPcNext;
            end else begin
                r_state <= FETCH_IDLE;
                r_req   <= 1'b0;
            end
        end
    end

    assign w_pushEntry = '{pc: r_addr, inst: imem_rdata_i};

    inst_fetch_unit_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .i_entry (w_pushEntry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_req_o   = r_req;
    assign imem_addr_o  = r_addr;
    assign inst_valid_o = w_valid;
    assign pc_o         = w_valid ? w_head.pc   : ZERO_WORD;
    assign inst_o       = w_valid ? w_head.inst : ZERO_WORD;

endmodule
